mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory between the instruction-fetch requester (port I, read-only) and the memory-stage requester (port D, read/write) of the pipelined CPU. It replaces the separate instruction and data arrays with one arbitrated array. It sequences each access through a three-state FSM, gives D priority over I on contention, and forbids back-to-back service of the same port. It also keeps saturating per-port transaction counters for performance monitoring.

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/sat_counter.sv | 37 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the arbitrated CPU memory port.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (I) and data (D) requesters.
// state  | meaning: IDLE | no access in flight; ACCESS | memory enabled; RESP | owner acked
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  i_count,
  output logic [CNT_W-1:0]  d_count
);

  arb_state_t        state_q, state_d;
  port_id_t          owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic cand_i;
  logic cand_d;
  logic in_access;
  logic in_resp;

  // The port being acked still holds req this cycle, so it is not a candidate.
  always_comb begin
    cand_i = i_req;
    cand_d = d_req;
    if (state_q == RESP) begin
      if (owner_q == PORT_I) begin
        cand_i = 1'b0;
      end else begin
        cand_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (cand_d) begin
          state_d = ACCESS;
          owner_d = PORT_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
        end else if (cand_i) begin
          state_d = ACCESS;
          owner_d = PORT_I;
          addr_d  = i_addr;
          we_d    = 1'b0;
          wdata_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= PORT_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Everything below is decoded from async-reset registers, so reset zeroes it at once.
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  assign mem_en    = in_access;
  assign mem_we    = in_access & we_q;
  assign mem_addr  = in_access ? addr_q : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

  assign i_ack   = in_resp & (owner_q == PORT_I);
  assign d_ack   = in_resp & (owner_q == PORT_D);
  assign i_rdata = i_ack ? mem_rdata : '0;
  assign d_rdata = (d_ack && !we_q) ? mem_rdata : '0;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_i_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (i_ack),
    .clr_i  (cnt_clr),
    .count_o(i_count)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_d_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (d_ack),
    .clr_i  (cnt_clr),
    .count_o(d_count)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle plus literal pins.
module tb_mem_port_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          cnt_clr;
  logic [CW-1:0] i_count;
  logic [CW-1:0] d_count;

  logic           i_ack2, d_ack2, mem_en2, mem_we2;
  logic [DW-1:0]  i_rdata2, d_rdata2, mem_wdata2;
  logic [AW-1:0]  mem_addr2;
  logic [CW2-1:0] i_count2, d_count2;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cnt_clr(cnt_clr), .i_count(i_count), .d_count(d_count)
  );

  // Narrow-counter instance sharing all stimulus; only its counters are of interest.
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack2), .i_rdata(i_rdata2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack2), .d_rdata(d_rdata2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata), .cnt_clr(cnt_clr), .i_count(i_count2), .d_count(d_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: synchronous read, data valid the cycle after mem_en.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] mem_rd_q;
  assign mem_rdata = mem_rd_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else mem_rd_q = mem[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction granted at edge g occupies the cycle after edge g with the
  // memory access and the cycle after edge g+1 with the ack; the next grant may happen
  // at edge g+2 (excluding the port just acked) or at any later edge.
  logic [DW-1:0] ref_mem [32];
  int            edge_n  = 0;
  bit            g_valid = 0;
  int            g_edge  = 0;
  bit            g_own_d = 0;
  logic [AW-1:0] g_addr  = '0;
  bit            g_we    = 0;
  logic [DW-1:0] g_wdata = '0;
  logic [DW-1:0] g_rd    = '0;
  int            m_icnt  = 0;
  int            m_dcnt  = 0;
  bit            m_ci, m_cd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_valid = 0;
      m_icnt  = 0;
      m_dcnt  = 0;
    end else begin
      if (g_valid && edge_n == g_edge + 1) begin
        g_rd = ref_mem[g_addr];
        if (g_we) ref_mem[g_addr] = g_wdata;
      end
      if (cnt_clr) begin
        m_icnt = 0;
        m_dcnt = 0;
      end else if (g_valid && edge_n == g_edge + 2) begin
        if (g_own_d) m_dcnt++;
        else m_icnt++;
      end
      if (!g_valid || edge_n >= g_edge + 2) begin
        m_ci = i_req && !(g_valid && edge_n == g_edge + 2 && !g_own_d);
        m_cd = d_req && !(g_valid && edge_n == g_edge + 2 && g_own_d);
        if (m_cd) begin
          g_own_d = 1; g_addr = d_addr; g_we = d_we; g_wdata = d_wdata;
        end else if (m_ci) begin
          g_own_d = 0; g_addr = i_addr; g_we = 0; g_wdata = '0;
        end
        if (m_cd || m_ci) begin
          g_valid = 1;
          g_edge  = edge_n;
        end
      end
      edge_n++;
    end
  end

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  int            i_ack_win = -1;
  int            d_ack_win = -1;
  int            we_win    = -1;
  logic [DW-1:0] i_last    = '0;
  logic [DW-1:0] d_last    = '0;
  bit            ack_log[$];

  always @(negedge clk) begin
    bit acc, rsp, e_iack, e_dack;
    acc    = rst_n && g_valid && (g_edge == edge_n - 1);
    rsp    = rst_n && g_valid && (g_edge + 1 == edge_n - 1);
    e_iack = rsp && !g_own_d;
    e_dack = rsp && g_own_d;
    chk("mem_en", mem_en, acc);
    chk("mem_we", mem_we, acc && g_we);
    chk("mem_addr", mem_addr, acc ? g_addr : '0);
    chk("mem_wdata", mem_wdata, acc ? g_wdata : '0);
    chk("i_ack", i_ack, e_iack);
    chk("i_rdata", i_rdata, e_iack ? g_rd : '0);
    chk("d_ack", d_ack, e_dack);
    chk("d_rdata", d_rdata, (e_dack && !g_we) ? g_rd : '0);
    chk("i_count", i_count, sat(m_icnt, CW));
    chk("d_count", d_count, sat(m_dcnt, CW));
    chk("i_count_w2", i_count2, sat(m_icnt, CW2));
    chk("d_count_w2", d_count2, sat(m_dcnt, CW2));
    if (mem_we) we_win = edge_n;
    if (i_ack) begin i_ack_win = edge_n; i_last = i_rdata; ack_log.push_back(1'b0); end
    if (d_ack) begin d_ack_win = edge_n; d_last = d_rdata; ack_log.push_back(1'b1); end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic i_fetch(input logic [AW-1:0] a);
    bit seen = 0;
    i_addr = a;
    i_req  = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (i_ack) seen = 1;
    end
    chk("i_ack_timeout", seen, 1'b1);
    step();
    i_req = 1'b0;
  endtask

  task automatic d_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input bit clr_on_ack);
    bit seen = 0;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (d_ack) seen = 1;
    end
    chk("d_ack_timeout", seen, 1'b1);
    if (clr_on_ack) cnt_clr = 1'b1;
    step();
    d_req   = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  int k;

  initial begin
    rst_n = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; cnt_clr = 0;
    for (int a = 0; a < 32; a++) begin
      mem[a]     = 32'h1000_0000 + a * 32'h111;
      ref_mem[a] = 32'h1000_0000 + a * 32'h111;
    end
    mem[5]     = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", {i_ack, d_ack, mem_en, mem_we, i_count, d_count}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single fetch
    k = edge_n;
    i_fetch(5);
    chk("fetch_ack_cycle", i_ack_win, k + 2);
    chk("fetch_data", i_last, 32'hDEAD_BEEF);
    chk("fetch_count", i_count, 1);

    // contention: D first, I two cycles later with no gap
    k = edge_n;
    fork
      i_fetch(2);
      d_access(1'b0, 3, '0, 1'b0);
    join
    chk("cont_d_cycle", d_ack_win, k + 2);
    chk("cont_d_data", d_last, 32'h1000_0333);
    chk("cont_i_cycle", i_ack_win, k + 4);
    chk("cont_i_data", i_last, 32'h1000_0222);

    // write then read back through the other port
    k = edge_n;
    d_access(1'b1, 7, 32'h1234_5678, 1'b0);
    chk("wr_we_cycle", we_win, k + 1);
    chk("wr_ack_cycle", d_ack_win, k + 2);
    chk("wr_rdata_zero", d_last, 0);
    chk("wr_mem", mem[7], 32'h1234_5678);
    i_fetch(7);
    chk("rd_after_wr", i_last, 32'h1234_5678);

    // fairness under continuous requests
    clear_counters();
    ack_log.delete();
    d_we = 0; d_addr = 4; i_addr = 6;
    d_req = 1; i_req = 1;
    repeat (20) @(posedge clk);
    #1 d_req = 0;
    step();
    i_req = 0;
    repeat (3) step();
    chk("fair_acks", ack_log.size(), 10);
    foreach (ack_log[n]) chk("fair_order", ack_log[n], (n % 2) == 0);
    chk("fair_d_count", d_count, 5);
    chk("fair_i_count", i_count, 5);

    // saturation and clear-on-ack
    clear_counters();
    for (int n = 0; n < 5; n++) d_access(1'b0, AW'(n), '0, 1'b0);
    chk("sat_w16", d_count, 5);
    chk("sat_w2", d_count2, 3);
    d_access(1'b0, 1, '0, 1'b1);
    chk("clr_w16", d_count, 0);
    chk("clr_w2", d_count2, 0);

    // reset during a D write in ACCESS
    d_we = 1; d_addr = 10; d_wdata = 32'hA5A5_A5A5; d_req = 1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);
    d_req = 0;
    step();
    chk("rst_no_write", mem[10], 32'h1000_0AAA);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    k = edge_n;
    i_fetch(10);
    chk("post_rst_cycle", i_ack_win, k + 2);
    chk("post_rst_data", i_last, 32'h1000_0AAA);
    chk("post_rst_count", i_count, 1);

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
